// File: rtl/pipeline_ctrl.sv
// Hazard, stall and forwarding control for the five-stage core, including a
// handshaked data-memory sequencer with a timeout watchdog.
module pipeline_ctrl #(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic [1:0]       ResultSrcE,
   input  logic             PCSrcE,
   input  logic [4:0]       RdM,
   input  logic [4:0]       RdW,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             MemReqM,
   input  logic             MemReadyM,
   output logic             MemValidM,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic             MemErr,
   output logic [CNT_W-1:0] StallCount
);

   localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, ERROR} state_t;

   state_t        state;
   logic [TW-1:0] tmo_cnt;
   logic          mem_stall;
   logic          lw_stall;

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic [4:0] rd_m, input logic wr_m,
                                          input logic [4:0] rd_w, input logic wr_w);
      if (wr_m && rd_m != 5'd0 && rd_m == rs)
         return 2'b10;
      else if (wr_w && rd_w != 5'd0 && rd_w == rs)
         return 2'b01;
      else
         return 2'b00;
   endfunction

   always_comb begin
      mem_stall = 1'b1;
      case (state)
         IDLE:    mem_stall = MemReqM & ~MemReadyM;
         WAIT:    mem_stall = ~MemReadyM;
         default: mem_stall = 1'b1;
      endcase
   end

   assign lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));

   // A memory stall freezes every stage, so branch and load-use flushes wait
   // until EX is released and the same instruction presents them again.
   assign StallF    = mem_stall | lw_stall;
   assign StallD    = mem_stall | lw_stall;
   assign StallE    = mem_stall;
   assign StallM    = mem_stall;
   assign FlushW    = mem_stall;
   assign FlushD    = ~mem_stall & PCSrcE;
   assign FlushE    = ~mem_stall & (lw_stall | PCSrcE);
   assign MemValidM = (state != ERROR) & MemReqM;

   assign ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
   assign ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         tmo_cnt <= '0;
         MemErr  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (MemReqM && !MemReadyM) begin
                  state   <= WAIT;
                  tmo_cnt <= '0;
               end
            end
            WAIT: begin
               if (MemReadyM) begin
                  state <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
                  // The IDLE request cycle is the first not-ready cycle.
                  if (tmo_cnt == TW'(MEM_TIMEOUT - 2)) begin
                     state  <= ERROR;
                     MemErr <= 1'b1;
                  end
               end
            end
            default: begin
               state  <= ERROR;
               MemErr <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         StallCount <= '0;
      else if (StallF && (StallCount != {CNT_W{1'b1}}))
         StallCount <= StallCount + 1'b1;
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed and random checks of pipeline_ctrl against a cycle-level model.
module tb_pipeline_ctrl;
   localparam int MT = 4;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst;
   logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic [1:0] ResultSrcE;
   logic PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
   logic MemValidM, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
   logic [1:0] ForwardAE, ForwardBE;
   logic [CW-1:0] StallCount;

   pipeline_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemReqM(MemReqM), .MemReadyM(MemReadyM), .MemValidM(MemValidM),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .MemErr(MemErr), .StallCount(StallCount)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Model: error latch, "access outstanding" flag, run of not-ready cycles,
   // and a plain integer stall-cycle count clipped at the counter maximum.
   bit m_err, m_busy;
   int m_run, m_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit exp_mstall();
      if (m_err) return 1'b1;
      if (m_busy) return !MemReadyM;
      return MemReqM && !MemReadyM;
   endfunction

   function automatic bit exp_lw();
      return ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
   endfunction

   function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
      if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
      if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
      return 2'b00;
   endfunction

   task automatic model_reset();
      m_err = 0; m_busy = 0; m_run = 0; m_cnt = 0;
   endtask

   task automatic check_outputs(input string ph);
      bit ms, lw;
      ms = exp_mstall();
      lw = exp_lw();
      chk({ph, ":StallF"}, StallF, ms | lw);
      chk({ph, ":StallD"}, StallD, ms | lw);
      chk({ph, ":StallE"}, StallE, ms);
      chk({ph, ":StallM"}, StallM, ms);
      chk({ph, ":FlushW"}, FlushW, ms);
      chk({ph, ":FlushD"}, FlushD, !ms && PCSrcE);
      chk({ph, ":FlushE"}, FlushE, !ms && (lw || PCSrcE));
      chk({ph, ":MemValidM"}, MemValidM, !m_err && MemReqM);
      chk({ph, ":MemErr"}, MemErr, m_err);
      chk({ph, ":StallCount"}, 32'(StallCount), 32'(m_cnt));
      chk({ph, ":ForwardAE"}, 32'(ForwardAE), 32'(exp_fwd(Rs1E)));
      chk({ph, ":ForwardBE"}, 32'(ForwardBE), 32'(exp_fwd(Rs2E)));
   endtask

   // Called at posedge+1; checks at the falling edge, then advances one cycle.
   task automatic step(input string ph);
      bit ms, lw;
      @(negedge clk);
      check_outputs(ph);
      ms = exp_mstall();
      lw = exp_lw();
      @(posedge clk);
      if ((ms || lw) && m_cnt < CMAX) m_cnt++;
      if (!m_err) begin
         if (ms) begin
            m_run++;
            m_busy = 1;
            if (m_run == MT) m_err = 1;
         end else begin
            m_run = 0;
            m_busy = 0;
         end
      end
      #1;
   endtask

   task automatic zero_inputs();
      Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
      ResultSrcE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
      MemReqM = 0; MemReadyM = 0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      zero_inputs();
      model_reset();
      rst = 1'b1;
      #12;
      check_outputs("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Load-use hazard, then the same registers with RdE = x0.
      ResultSrcE = 2'b01; RdE = 5; Rs1D = 5;
      #1;
      chk("lu_stallf", StallF, 1'b1);
      chk("lu_flushe", FlushE, 1'b1);
      step("lu");
      RdE = 0;
      #1;
      chk("lu_x0_stallf", StallF, 1'b0);
      step("lu_x0");

      // Forwarding priority.
      zero_inputs();
      RdM = 7; RdW = 7; Rs1E = 7; RegWriteM = 1; RegWriteW = 1;
      #1;
      chk("fwd_mem", 32'(ForwardAE), 32'd2);
      step("fwd_mem");
      RegWriteM = 0;
      #1;
      chk("fwd_wb", 32'(ForwardAE), 32'd1);
      step("fwd_wb");
      RdM = 0; RdW = 0;
      #1;
      chk("fwd_none", 32'(ForwardAE), 32'd0);
      step("fwd_none");

      // Three-cycle memory wait.
      zero_inputs();
      pulse_reset();
      MemReqM = 1;
      for (int i = 0; i < 3; i++) step("memwait");
      MemReadyM = 1;
      #1;
      chk("memwait_release", StallE, 1'b0);
      step("memwait_rel");
      chk("memwait_count", 32'(StallCount), 32'd3);
      MemReqM = 0; MemReadyM = 0;
      step("memwait_idle");

      // Branch resolved while the memory is stalling.
      MemReqM = 1;
      step("br_req");
      PCSrcE = 1;
      #1;
      chk("br_wait_flushd", FlushD, 1'b0);
      chk("br_wait_flushe", FlushE, 1'b0);
      step("br_wait");
      MemReadyM = 1;
      #1;
      chk("br_rel_flushd", FlushD, 1'b1);
      chk("br_rel_flushe", FlushE, 1'b1);
      step("br_rel");
      zero_inputs();
      step("br_idle");

      // Watchdog timeout, then asynchronous reset out of ERROR.
      pulse_reset();
      MemReqM = 1;
      for (int i = 0; i < 3; i++) step("tmo");
      chk("tmo_not_yet", MemErr, 1'b0);
      step("tmo4");
      chk("tmo_memerr", MemErr, 1'b1);
      for (int i = 0; i < 2; i++) step("tmo_err");
      zero_inputs();
      #1;
      chk("err_stallf", StallF, 1'b1);
      rst = 1'b1;
      #1;
      chk("arst_stallf", StallF, 1'b0);
      chk("arst_memerr", MemErr, 1'b0);
      chk("arst_count", 32'(StallCount), 32'd0);
      chk("arst_flushw", FlushW, 1'b0);
      rst = 1'b0;
      model_reset();
      #1;
      @(posedge clk);
      #1;

      // Stall counter saturation.
      ResultSrcE = 2'b01; RdE = 3; Rs2D = 3;
      for (int i = 0; i < 20; i++) step("sat");
      chk("sat_count", 32'(StallCount), 32'(CMAX));
      step("sat_hold");
      chk("sat_hold", 32'(StallCount), 32'(CMAX));

      // Random traffic; small register indices make hazards frequent.
      zero_inputs();
      pulse_reset();
      for (int n = 0; n < 400; n++) begin
         Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
         Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
         RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
         RdW  = 5'($urandom_range(0, 3));
         ResultSrcE = 2'($urandom_range(0, 3));
         PCSrcE    = ($urandom_range(0, 3) == 0);
         RegWriteM = 1'($urandom);
         RegWriteW = 1'($urandom);
         MemReqM   = 1'($urandom);
         MemReadyM = ($urandom_range(0, 3) != 0);
         if (m_err && $urandom_range(0, 3) == 0) pulse_reset();
         step("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and stall scheduler for the five-stage pipelined RISC-V core. It drives the enable and clear inputs of the FD, DE, EM and MW pipeline registers. It also generates the EX-stage forwarding selects. It sequences a handshaked, variable-latency data memory through a small FSM with a watchdog. It sits beside the datapath and owns no data, only control.

## Interface
- MEM_TIMEOUT, 64: maximum cycles spent in WAIT before declaring a memory error (≥ 2).
- CNT_W, 32: width of the stall-cycle counter.
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- Rs1D, Rs2D  in  5  source registers in ID.
- Rs1E, Rs2E, RdE  in  5  source and destination registers in EX.
- ResultSrcE  in  2  EX result select; 2'b01 = load.
- PCSrcE  in  1  taken branch or jump resolved in EX.
- RdM, RdW  in  5  destination registers in MEM and WB.
- RegWriteM, RegWriteW  in  1  register-write enables in MEM and WB.
- MemReqM  in  1  a load or store occupies MEM.
- MemReadyM  in  1  data memory completes the current access this cycle.
- MemValidM  out  1  request strobe to data memory.
- ForwardAE, ForwardBE  out  2  EX operand select: 00 = register file, 01 = WB result, 10 = MEM ALU result.
- StallF, StallD, StallE, StallM  out  1  hold the PC, FD, DE and EM registers; each is the active-high complement of that register's enable.
- FlushD, FlushE, FlushW  out  1  synchronous clear of FD, DE and MW.
- MemErr  out  1  sticky memory-timeout flag.
- StallCount  out  CNT_W  cycles in which StallF was asserted, saturating.

## Operation
- FSM states: IDLE, WAIT, ERROR. Reset state is IDLE.
- IDLE, MemReqM=1, MemReadyM=1: zero-wait access; no stall; stay in IDLE.
- IDLE, MemReqM=1, MemReadyM=0: memStall=1 this cycle; go to WAIT; clear the timeout counter.
- WAIT, MemReadyM=0: memStall=1; increment the timeout counter. When the counter reaches MEM_TIMEOUT-1, go to ERROR.
- WAIT, MemReadyM=1: memStall=0 this cycle so the pipeline advances; go to IDLE.
- ERROR: memStall=1 permanently and MemErr=1. Only rst exits this state.
- MemValidM = MemReqM whenever the state is not ERROR.
- While memStall=1: StallF=StallD=StallE=StallM=1 and FlushW=1, which inserts a bubble into MW. FlushD=0 and FlushE=0. A concurrent load-use stall or PCSrcE is deferred; EX is held, so the branch re-presents once the stall releases.
- lwStall = (ResultSrcE==2'b01) && (RdE!=0) && (RdE==Rs1D || RdE==Rs2D).
- Without memStall:
  - StallF = StallD = lwStall.
  - FlushE = lwStall | PCSrcE.
  - FlushD = PCSrcE.
  - StallE, StallM and FlushW are 0.
- Branch and load-use in the same cycle: FlushD=1 and FlushE=1. StallF and StallD are still asserted, but the flush wins at FD. The PC still loads the branch target, because PCSrcE overrides StallF in the PC mux.
- ForwardAE:
  - 10 if RegWriteM && RdM!=0 && RdM==Rs1E;
  - else 01 if RegWriteW && RdW!=0 && RdW==Rs1E;
  - else 00.
  - MEM has priority over WB. ForwardBE follows the same rule using Rs2E.
- Forwarding is purely combinational and independent of stall state.
- StallCount increments on each clock edge with StallF=1. It holds at all-ones and never wraps.

## Timing
- All stall, flush and forward outputs are combinational from the inputs and the registered state; there is no added latency.
- The state, the timeout counter, MemErr and StallCount update on the rising edge of clk.
- rst is asynchronous. Its assertion forces: state IDLE, timeout counter 0, MemErr 0, StallCount 0.
- With all inputs at 0 under reset, every output is 0.
- rst during WAIT aborts the access; the core restarts from reset.
- Minimum memory stall is 1 cycle, with MemReadyM arriving one cycle after the request.
- ERROR is entered on the edge after MEM_TIMEOUT consecutive not-ready cycles, counting from the IDLE request cycle.

## Test plan
- Load-use: ResultSrcE=01, RdE=5, Rs1D=5 → StallF=StallD=FlushE=1 for one cycle; RdE=0 with the same Rs1D → no stall.
- Forward priority: RdM=RdW=Rs1E=7 with both RegWrite=1 → ForwardAE=10; clear RegWriteM → 01; set RdM=RdW=0 → 00.
- Memory wait: MemReqM=1 with MemReadyM low for 3 cycles, then high → Stall* and FlushW=1 for exactly 3 cycles, state IDLE afterwards, StallCount=3.
- Branch during memory wait: PCSrcE=1 while in WAIT → FlushD=FlushE=0 until MemReadyM; then FlushD=FlushE=1 in the release cycle.
- Timeout: MEM_TIMEOUT=4, MemReadyM held 0 → MemErr rises after the 4th stall cycle, Stall* remain high; rst mid-ERROR → all outputs 0 immediately, without waiting for a clock edge.
- Counter saturation: CNT_W=4, StallF held 20 cycles → StallCount=15 and it stays there.
